// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state instruction sequencer (IDLE -> DECODE -> EXECUTE
// -> WRITEBACK) that hands one instruction at a time to a decode/ALU/regfile
// datapath. Only ADD and ADDI are supported; any other opcode is dropped with
// an illegal pulse.
//
// Build option:
//   EXEC_SEQ_PERF_EN  defined   -> retired_cnt counts retire pulses (wraps)
//                     undefined -> retired_cnt is tied to zero, no counter flops
//
// State table
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_IDLE      | waiting for an instruction, instr_ready high
//   S_DECODE    | ir holds the instruction; opcode checked, operand selects set
//   S_EXECUTE   | one cycle for the ALU to settle
//   S_WRITEBACK | register write and retire on exit
//
// The reg_write / retire / illegal pulses are decoded from the current state
// and stall: they must appear in the cycle the state is actually left, which
// a stall can postpone, so they cannot be precomputed a cycle early.

module exec_sequencer #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] instr,
   output logic              instr_ready,
   input  logic              stall,
   output logic [DATA_W-1:0] ir,
   output logic              alu_src,
   output logic [1:0]        alu_op,
   output logic [4:0]        wr_reg,
   output logic              reg_write,
   output logic              retire,
   output logic              illegal,
   output logic              busy,
   output logic [CNT_W-1:0]  retired_cnt
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_DECODE    = 2'd1,
      S_EXECUTE   = 2'd2,
      S_WRITEBACK = 2'd3
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALU_OP_ADD  = 2'b10;
   localparam logic [1:0] ALU_OP_ADDI = 2'b00;

   state_t     state;
   logic [5:0] opcode;
   logic [4:0] fld_rt;
   logic [4:0] fld_rd;
   logic       op_legal;

   assign opcode = ir[31:26];
   assign fld_rt = ir[20:16];
   assign fld_rd = ir[15:11];

   assign op_legal = (opcode == OP_ADD) || (opcode == OP_ADDI);

   // Handshake and exit pulses decoded from the current state.
   assign instr_ready = (state == S_IDLE);
   assign illegal     = (state == S_DECODE) && !stall && !op_legal;
   assign retire      = (state == S_WRITEBACK) && !stall;
   // Register 0 is never written; the instruction still retires.
   assign reg_write   = retire && (wr_reg != 5'd0);

   // Sequencer FSM with registered instruction, operand selects and busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ir      <= '0;
         alu_src <= 1'b0;
         alu_op  <= 2'b00;
         wr_reg  <= 5'd0;
         busy    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               // stall is deliberately not looked at here
               if (instr_valid) begin
                  ir    <= instr;
                  state <= S_DECODE;
                  busy  <= 1'b1;
               end
            end
            S_DECODE: begin
               if (!stall) begin
                  if (opcode == OP_ADD) begin
                     alu_src <= 1'b0;
                     alu_op  <= ALU_OP_ADD;
                     wr_reg  <= fld_rd;
                     state   <= S_EXECUTE;
                  end else if (opcode == OP_ADDI) begin
                     alu_src <= 1'b1;
                     alu_op  <= ALU_OP_ADDI;
                     wr_reg  <= fld_rt;
                     state   <= S_EXECUTE;
                  end else begin
                     // dropped: operand selects keep their previous values
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            S_EXECUTE: begin
               if (!stall) begin
                  state <= S_WRITEBACK;
               end
            end
            S_WRITEBACK: begin
               if (!stall) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef EXEC_SEQ_PERF_EN
   logic [CNT_W-1:0] retire_count;

   // Retired-instruction counter; wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retire_count <= '0;
      end else if (retire) begin
         retire_count <= retire_count + 1'b1;
      end
   end

   assign retired_cnt = retire_count;
`else
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer. A transaction-level model predicts
// every output on every falling edge; directed scenarios add literal latency
// and field expectations. Set EXEC_SEQ_PERF_EN consistently for RTL and bench.

module tb_exec_sequencer;

   localparam int DW = 32;
   localparam int CW = 2;

   localparam logic [31:0] I_ADD     = 32'h0041_1800;  // add r3 = r2 + r1
   localparam logic [31:0] I_ADDI    = 32'h2022_000A;  // addi r2 = r1 + 10
   localparam logic [31:0] I_BAD     = 32'hFC00_0000;  // opcode 111111
   localparam logic [31:0] I_ADD_R0  = 32'h0041_0000;  // add r0 = r2 + r1
   localparam logic [31:0] I_JUNK    = 32'h2063_000F;  // offered while busy

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic [DW-1:0] instr = '0;
   logic          stall = 1'b0;
   logic          instr_ready;
   logic [DW-1:0] ir;
   logic          alu_src;
   logic [1:0]    alu_op;
   logic [4:0]    wr_reg;
   logic          reg_write;
   logic          retire;
   logic          illegal;
   logic          busy;
   logic [CW-1:0] retired_cnt;

   exec_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .stall       (stall),
      .ir          (ir),
      .alu_src     (alu_src),
      .alu_op      (alu_op),
      .wr_reg      (wr_reg),
      .reg_write   (reg_write),
      .retire      (retire),
      .illegal     (illegal),
      .busy        (busy),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // An accepted instruction needs 1 unstalled cycle to be judged legal or
   // dropped, and 3 unstalled cycles in total to retire.
   logic        m_busy = 1'b0;
   int          m_steps = 0;
   logic        m_legal = 1'b0;
   logic [31:0] m_ir = '0;
   logic        m_src = 1'b0;
   logic [1:0]  m_op = 2'b00;
   logic [4:0]  m_wr = 5'd0;
   logic        m_nsrc = 1'b0;
   logic [1:0]  m_nop = 2'b00;
   logic [4:0]  m_ndst = 5'd0;
   int          m_cnt = 0;
   logic        e_ill, e_wb;
   logic [5:0]  m_opc;
   int          e_cnt;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_steps = 0; m_ir = '0;
         m_src = 1'b0; m_op = 2'b00; m_wr = 5'd0; m_cnt = 0;
      end
      e_ill = m_busy && !m_legal && (m_steps == 0) && !stall;
      e_wb  = m_busy &&  m_legal && (m_steps == 2) && !stall;
`ifdef EXEC_SEQ_PERF_EN
      e_cnt = m_cnt % (1 << CW);
`else
      e_cnt = 0;
`endif
      check("m_instr_ready", 32'(instr_ready), 32'(!m_busy));
      check("m_busy",        32'(busy),        32'(m_busy));
      check("m_ir",          ir,               m_ir);
      check("m_alu_src",     32'(alu_src),     32'(m_src));
      check("m_alu_op",      32'(alu_op),      32'(m_op));
      check("m_wr_reg",      32'(wr_reg),      32'(m_wr));
      check("m_illegal",     32'(illegal),     32'(e_ill));
      check("m_retire",      32'(retire),      32'(e_wb));
      check("m_reg_write",   32'(reg_write),   32'(e_wb && (m_wr != 5'd0)));
      check("m_retired_cnt", 32'(retired_cnt), 32'(e_cnt));
      if (rst_n) begin
         if (!m_busy) begin
            if (instr_valid) begin
               m_busy  = 1'b1;
               m_steps = 0;
               m_ir    = instr;
               m_opc   = instr[31:26];
               m_legal = (m_opc == 6'd0) || (m_opc == 6'd8);
               m_nsrc  = (m_opc == 6'd8);
               m_nop   = (m_opc == 6'd0) ? 2'b10 : 2'b00;
               m_ndst  = (m_opc == 6'd0) ? instr[15:11] : instr[20:16];
            end
         end else if (!stall) begin
            if (m_steps == 0) begin
               if (!m_legal) m_busy = 1'b0;
               else begin
                  m_src = m_nsrc; m_op = m_nop; m_wr = m_ndst;
               end
            end else if (m_steps == 2) begin
               m_busy = 1'b0;
               m_cnt++;
            end
            m_steps++;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Offer w for one cycle (edge N transfers it), then observe cycles N+k.
   // stall is high in cycles N+s_at .. N+s_at+s_len-1; stall_idle raises it
   // during the transfer cycle itself.
   task automatic issue(input logic [31:0] w, input logic stall_idle,
                        input int s_at, input int s_len,
                        output int lat_wr, output int lat_ill, output int lat_rdy,
                        output int n_wr, output int n_ret);
      lat_wr = 0; lat_ill = 0; lat_rdy = 0; n_wr = 0; n_ret = 0;
      @(posedge clk); #1;
      instr_valid = 1'b1; instr = w; stall = stall_idle;
      @(posedge clk); #1;
      for (int k = 1; k <= 30 && lat_rdy == 0; k++) begin
         stall       = (k >= s_at) && (k < s_at + s_len);
         instr_valid = (k == 1);
         instr       = I_JUNK;
         @(negedge clk);
         if (reg_write) begin n_wr++; if (lat_wr == 0) lat_wr = k; end
         if (retire) n_ret++;
         if (illegal && lat_ill == 0) lat_ill = k;
         if (instr_ready) lat_rdy = k;
         @(posedge clk); #1;
      end
      stall = 1'b0; instr_valid = 1'b0;
      check("ready_returned", 32'(lat_rdy != 0), 32'd1);
   endtask

   int lw, li, lr, nw, nr;

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 32'(instr_ready), 32'd1);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_ir",    ir, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ADD r3 = r2 + r1
      issue(I_ADD, 1'b0, 0, 0, lw, li, lr, nw, nr);
      check("add_lat_wr",  32'(lw), 32'd3);
      check("add_lat_rdy", 32'(lr), 32'd4);
      check("add_n_wr",    32'(nw), 32'd1);
      check("add_n_ret",   32'(nr), 32'd1);
      check("add_wr_reg",  32'(wr_reg), 32'd3);
      check("add_alu_src", 32'(alu_src), 32'd0);
      check("add_alu_op",  32'(alu_op), 32'd2);

      // ADDI r2 = r1 + 10, stall held high in IDLE must not block the transfer
      issue(I_ADDI, 1'b1, 0, 0, lw, li, lr, nw, nr);
      check("addi_lat_wr",  32'(lw), 32'd3);
      check("addi_n_wr",    32'(nw), 32'd1);
      check("addi_wr_reg",  32'(wr_reg), 32'd2);
      check("addi_alu_src", 32'(alu_src), 32'd1);
      check("addi_alu_op",  32'(alu_op), 32'd0);

      // unsupported opcode
      issue(I_BAD, 1'b0, 0, 0, lw, li, lr, nw, nr);
      check("bad_lat_ill", 32'(li), 32'd1);
      check("bad_n_wr",    32'(nw), 32'd0);
      check("bad_n_ret",   32'(nr), 32'd0);
      check("bad_lat_rdy", 32'(lr), 32'd2);
      check("bad_keep_wr", 32'(wr_reg), 32'd2);

      // unsupported opcode with a 2-cycle stall in DECODE
      issue(I_BAD, 1'b0, 1, 2, lw, li, lr, nw, nr);
      check("bad_stall_lat_ill", 32'(li), 32'd3);

      // ADD, 3 stall cycles in EXECUTE
      issue(I_ADD, 1'b0, 2, 3, lw, li, lr, nw, nr);
      check("exe_stall_lat_wr",  32'(lw), 32'd6);
      check("exe_stall_n_wr",    32'(nw), 32'd1);
      check("exe_stall_lat_rdy", 32'(lr), 32'd7);

      // ADD, 2 stall cycles in DECODE
      issue(I_ADD, 1'b0, 1, 2, lw, li, lr, nw, nr);
      check("dec_stall_lat_wr", 32'(lw), 32'd5);
      check("dec_stall_n_wr",   32'(nw), 32'd1);

      // ADDI, 2 stall cycles in WRITEBACK
      issue(I_ADDI, 1'b0, 3, 2, lw, li, lr, nw, nr);
      check("wb_stall_lat_wr",  32'(lw), 32'd5);
      check("wb_stall_n_wr",    32'(nw), 32'd1);
      check("wb_stall_n_ret",   32'(nr), 32'd1);
      check("wb_stall_lat_rdy", 32'(lr), 32'd6);

      // ADD to r0: retires without a register write
      issue(I_ADD_R0, 1'b0, 0, 0, lw, li, lr, nw, nr);
      check("r0_n_ret",   32'(nr), 32'd1);
      check("r0_n_wr",    32'(nw), 32'd0);
      check("r0_wr_reg",  32'(wr_reg), 32'd0);
      check("r0_lat_rdy", 32'(lr), 32'd4);

      // reset while in EXECUTE
      @(posedge clk); #1;
      instr_valid = 1'b1; instr = I_ADD;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_ready",     32'(instr_ready), 32'd1);
      check("arst_busy",      32'(busy), 32'd0);
      check("arst_reg_write", 32'(reg_write), 32'd0);
      check("arst_retire",    32'(retire), 32'd0);
      check("arst_ir",        ir, 32'd0);
      check("arst_wr_reg",    32'(wr_reg), 32'd0);
      check("arst_alu",       32'({alu_src, alu_op}), 32'd0);
      check("arst_cnt",       32'(retired_cnt), 32'd0);
      nw = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (reg_write) nw++;
      end
      check("arst_no_wr", 32'(nw), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; instr_valid = 1'b1; instr = I_ADDI;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd1);
      check("post_rst_ir",   ir, I_ADDI);
      nr = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (retire) nr++;
      end
      check("post_rst_ret", 32'(nr), 32'd1);

      // four more retires: five since reset, counter is 2 bits wide
      for (int j = 0; j < 4; j++) begin
         issue((j % 2 == 0) ? I_ADD : I_ADDI, 1'b0, 0, 0, lw, li, lr, nw, nr);
      end
      @(negedge clk);
`ifdef EXEC_SEQ_PERF_EN
      check("cnt_wrap", 32'(retired_cnt), 32'd1);
`else
      check("cnt_tied", 32'(retired_cnt), 32'd0);
`endif

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 Parameter: DATA_W, default 32, instruction/ir width (fixed fields below assume 32).
REQ-002 Parameter: CNT_W, default 16, width of retired-instruction counter.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: instr_valid  input  1  instruction source offers instr.
REQ-006 Port: instr  input  DATA_W  offered instruction word.
REQ-007 Port: instr_ready  output  1  sequencer accepts instr this cycle.
REQ-008 Port: stall  input  1  freeze request from downstream.
REQ-009 Port: ir  output  DATA_W  instruction register, drives decode unit.
REQ-010 Port: alu_src  output  1  0 = register B operand, 1 = immediate.
REQ-011 Port: alu_op  output  2  ALU operation select.
REQ-012 Port: wr_reg  output  5  register-file write address.
REQ-013 Port: reg_write  output  1  register-file write enable, one-cycle pulse.
REQ-014 Port: retire  output  1  one-cycle pulse, instruction completed.
REQ-015 Port: illegal  output  1  one-cycle pulse, unsupported opcode dropped.
REQ-016 Port: busy  output  1  high in any state other than IDLE.
REQ-017 Port: retired_cnt  output  CNT_W  retired-instruction count (REQ-033).

Function
REQ-018 FSM states SHALL be IDLE, DECODE, EXECUTE, WRITEBACK; encoding is implementation choice.
REQ-019 instr_ready SHALL equal 1 exactly when state is IDLE; transfer = instr_valid & instr_ready.
REQ-020 On transfer: ir <= instr, state -> DECODE; instr ignored at all other times.
REQ-021 Opcode = ir[31:26]; rs = ir[25:21], rt = ir[20:16], rd = ir[15:11].
REQ-022 DECODE, opcode 6'b000000 (ADD): alu_src <= 0, alu_op <= 2'b10, wr_reg <= rd; -> EXECUTE.
REQ-023 DECODE, opcode 6'b001000 (ADDI): alu_src <= 1, alu_op <= 2'b00, wr_reg <= rt; -> EXECUTE.
REQ-024 DECODE, any other opcode: illegal pulses 1 cycle, no reg_write, no retire, -> IDLE.
REQ-025 EXECUTE SHALL last one cycle (ALU settle), -> WRITEBACK.
REQ-026 WRITEBACK: reg_write = 1 and retire = 1 for one cycle, -> IDLE; reg_write forced 0 when wr_reg = 0 (retire still pulses).
REQ-027 Latency: transfer at edge N; reg_write high in cycle N+3; instr_ready high again in cycle N+4 (no stall).
REQ-028 stall = 1 in DECODE/EXECUTE/WRITEBACK SHALL hold state and all registered outputs; reg_write/retire/illegal assert only in the cycle the state is left.
REQ-029 stall SHALL have no effect in IDLE.
REQ-030 ir, alu_src, alu_op, wr_reg SHALL remain stable from DECODE exit until next transfer.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE; ir, alu_src, alu_op, wr_reg, reg_write, retire, illegal, busy, retired_cnt = 0.
REQ-032 Reset mid-instruction SHALL abort it with no reg_write; first transfer possible on first rising edge after rst_n rises.

Configuration
REQ-033 Macro EXEC_SEQ_PERF_EN: defined -> retired_cnt increments by 1 per retire pulse, wraps 2^CNT_W-1 -> 0, illegal does not count; undefined -> retired_cnt tied to 0, no counter flops.

Verification
REQ-034 Reset, instr_valid=1, instr=ADD r3=r2+r1 (0x00411800) -> reg_write cycle N+3, wr_reg=3, alu_src=0, alu_op=2'b10, retire=1.
REQ-035 instr=ADDI r2,r1,10 (0x2022000A) -> wr_reg=2, alu_src=1, alu_op=2'b00, reg_write one cycle.
REQ-036 instr opcode 6'b111111 -> illegal pulse at DECODE exit, no reg_write, instr_ready high next cycle.
REQ-037 ADD with stall=1 for 3 cycles during EXECUTE -> reg_write at N+6, single pulse; ADD with rd=0 -> retire=1, reg_write=0.
REQ-038 rst_n low in EXECUTE -> immediate IDLE, all outputs 0, no reg_write; with EXEC_SEQ_PERF_EN, CNT_W=2, 5 retires -> retired_cnt=1.
